// File: rtl/fifo_chain.sv
// fifo_chain: DEPTH x WIDTH shift-out FIFO with per-element used flags.
// Optional sticky error flags via `define FIFO_CHAIN_ERR_FLAGS_EN.
module fifo_chain #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_in_strobe,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_strobe,
  output logic [DEPTH-1:0] used,
`ifdef FIFO_CHAIN_ERR_FLAGS_EN
  input  logic             err_clear,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] shifted [DEPTH];
  logic [WIDTH-1:0] mem_n   [DEPTH];
  logic [DEPTH-1:0] used_n;
  logic [CW-1:0]    count_n;
  logic [CW-1:0]    wr_idx;
  logic             pop_ok;
  logic             push_ok;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AFULL_LEVEL));
  assign in_ready    = ~full | q_strobe;
  assign q           = mem[0];
  assign q_valid     = used[0];

  assign pop_ok  = q_strobe & ~empty;
  assign push_ok = d_in_strobe & (~full | pop_ok);

  // Push lands at the first free slot after any shift this cycle
  assign wr_idx  = pop_ok ? count - CW'(1) : count;

  always_comb begin
    count_n = count;
    unique case (1'b1)
      push_ok & ~pop_ok: count_n = count + CW'(1);
      pop_ok & ~push_ok: count_n = count - CW'(1);
      default:           count_n = count;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = mem[i+1];
    end
    shifted[DEPTH-1] = mem[DEPTH-1];
  end

  // Only occupied elements shift; the vacated top keeps stale data
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_n[i] = mem[i];
      if (pop_ok && (CW'(i + 1) < count)) begin
        mem_n[i] = shifted[i];
      end
      if (push_ok && (CW'(i) == wr_idx)) begin
        mem_n[i] = d_in;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      used_n[i] = (CW'(i) < count_n);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      used  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= mem_n[i];
      end
      used  <= used_n;
      count <= count_n;
    end
  end

`ifdef FIFO_CHAIN_ERR_FLAGS_EN
  logic ovf_ev;
  logic udf_ev;

  assign ovf_ev = d_in_strobe & ~push_ok;
  assign udf_ev = q_strobe & empty;

  // A fresh error wins over a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_ev | (overflow & ~err_clear);
      underflow <= udf_ev | (underflow & ~err_clear);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_chain.sv
// tb_fifo_chain: directed and random checks of fifo_chain
// against a queue model; err flags when FIFO_CHAIN_ERR_FLAGS_EN.
module tb_fifo_chain;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = D - 1;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  d_in = '0;
  logic          d_in_strobe = 1'b0;
  logic          q_strobe = 1'b0;
  logic          in_ready;
  logic [W-1:0]  q;
  logic          q_valid;
  logic [D-1:0]  used;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
`ifdef FIFO_CHAIN_ERR_FLAGS_EN
  logic          err_clear = 1'b0;
  logic          overflow;
  logic          underflow;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] mq[$];

  fifo_chain #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .d_in(d_in),
    .d_in_strobe(d_in_strobe),
    .in_ready(in_ready),
    .q(q),
    .q_valid(q_valid),
    .q_strobe(q_strobe),
    .used(used),
`ifdef FIFO_CHAIN_ERR_FLAGS_EN
    .err_clear(err_clear),
    .overflow(overflow),
    .underflow(underflow),
`endif
    .count(count),
    .empty(empty),
    .full(full),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the queue model follows the push/pop rules.
  task automatic drive(input logic push, input logic [W-1:0] data,
                       input logic pop, output logic rdy);
    logic pop_ok, push_ok;
    @(negedge clk);
    d_in_strobe = push;
    d_in = data;
    q_strobe = pop;
    #1 rdy = in_ready;
    @(posedge clk);
    pop_ok = pop && (mq.size() > 0);
    push_ok = push && ((mq.size() < D) || pop_ok);
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) mq.push_back(data);
    #1;
    d_in_strobe = 1'b0;
    q_strobe = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    mq.delete();
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (used !== '0) begin miscompares++; $display("FAIL reset_used got %b exp 0", used); end
    vectors++; if (q !== '0) begin miscompares++; $display("FAIL reset_q got %h exp 00", q); end
    vectors++; if (q_valid !== 1'b0) begin miscompares++; $display("FAIL reset_qvalid got %b exp 0", q_valid); end
    vectors++; if ({empty, full, almost_full} !== 3'b100) begin miscompares++; $display("FAIL reset_flags got %b exp 100", {empty, full, almost_full}); end
`ifdef FIFO_CHAIN_ERR_FLAGS_EN
    vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic r;
    drive(1'b1, 8'hAA, 1'b0, r);
    vectors++; if (q !== 8'hAA) begin miscompares++; $display("FAIL basic_q got %h exp aa", q); end
    vectors++; if (q_valid !== 1'b1) begin miscompares++; $display("FAIL basic_qvalid got %b exp 1", q_valid); end
    vectors++; if (used !== 4'b0001) begin miscompares++; $display("FAIL basic_used got %b exp 0001", used); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL basic_count got %0d exp 1", count); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL basic_empty got %b exp 0", empty); end
    drive(1'b0, 8'h00, 1'b1, r);
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_drain got %b exp 1", empty); end
  endtask

  task automatic test_fill_drop();
    logic r;
    logic [W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 1'b0, r);
      vectors++; if (almost_full !== (i >= 2)) begin miscompares++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, i >= 2); end
      vectors++; if (full !== (i == 3)) begin miscompares++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == 3); end
    end
    vectors++; if (used !== 4'b1111) begin miscompares++; $display("FAIL fill_used got %b exp 1111", used); end
    drive(1'b1, 8'h55, 1'b0, r);
    vectors++; if (r !== 1'b0) begin miscompares++; $display("FAIL drop_ready got %b exp 0", r); end
    vectors++; if (count !== 3'd4 || q !== 8'h11) begin miscompares++; $display("FAIL drop_state got %0d/%h exp 4/11", count, q); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (q !== vals[i]) begin miscompares++; $display("FAIL drain_q[%0d] got %h exp %h", i, q, vals[i]); end
      drive(1'b0, 8'h00, 1'b1, r);
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_pushpop();
    logic r;
    logic [W-1:0] exp_q [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 1; i <= 4; i++) drive(1'b1, W'(i * 8'h11), 1'b0, r);
    drive(1'b1, 8'h55, 1'b1, r);
    vectors++; if (r !== 1'b1) begin miscompares++; $display("FAIL fpp_ready got %b exp 1", r); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fpp_count got %0d exp 4", count); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (q !== exp_q[i]) begin miscompares++; $display("FAIL fpp_q[%0d] got %h exp %h", i, q, exp_q[i]); end
      drive(1'b0, 8'h00, 1'b1, r);
    end
  endtask

  task automatic test_empty_pushpop();
    logic r;
    do_reset();
    @(negedge clk);
    d_in_strobe = 1'b1;
    q_strobe = 1'b1;
    d_in = 8'h7E;
    #1;
    vectors++; if (q_valid !== 1'b0) begin miscompares++; $display("FAIL epp_nofall got %b exp 0", q_valid); end
    drive(1'b1, 8'h7E, 1'b1, r);
    vectors++; if (count !== 3'd1 || q !== 8'h7E) begin miscompares++; $display("FAIL epp_state got %0d/%h exp 1/7e", count, q); end
`ifdef FIFO_CHAIN_ERR_FLAGS_EN
    vectors++; if ({overflow, underflow} !== 2'b01) begin miscompares++; $display("FAIL epp_err got %b exp 01", {overflow, underflow}); end
`endif
  endtask

  task automatic test_async_reset();
    logic r;
    drive(1'b1, 8'hC1, 1'b0, r);
    drive(1'b1, 8'hC2, 1'b0, r);
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL areset_pre got %0d exp 3", count); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    mq.delete();
    vectors++; if (used !== '0 || count !== '0) begin miscompares++; $display("FAIL areset_used got %b/%0d exp 0/0", used, count); end
    vectors++; if (q !== '0 || empty !== 1'b1) begin miscompares++; $display("FAIL areset_q got %h/%b exp 00/1", q, empty); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic r, p, o, exp_rdy;
    logic [W-1:0] dv;
    logic [D-1:0] eu;
    int n;
    for (int k = 0; k < 400; k++) begin
      p = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      dv = W'($urandom);
      exp_rdy = (mq.size() < D) || o;
      drive(p, dv, o, r);
      n = mq.size();
      eu = D'((1 << n) - 1);
      vectors++; if (r !== exp_rdy) begin miscompares++; $display("FAIL rnd_ready[%0d] got %b exp %b", k, r, exp_rdy); end
      vectors++; if (count !== CW'(n) || used !== eu) begin miscompares++; $display("FAIL rnd_occ[%0d] got %0d/%b exp %0d/%b", k, count, used, n, eu); end
      vectors++; if ({empty, full, almost_full, q_valid} !== {n == 0, n == D, n >= AF, n > 0}) begin miscompares++; $display("FAIL rnd_flags[%0d] got %b exp %b", k, {empty, full, almost_full, q_valid}, {n == 0, n == D, n >= AF, n > 0}); end
      if (n > 0) begin
        vectors++; if (q !== mq[0]) begin miscompares++; $display("FAIL rnd_q[%0d] got %h exp %h", k, q, mq[0]); end
      end
    end
  endtask

`ifdef FIFO_CHAIN_ERR_FLAGS_EN
  task automatic test_err_flags();
    logic r;
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, W'(i), 1'b0, r);
    drive(1'b1, 8'h99, 1'b0, r);
    for (int i = 0; i < 5; i++) begin
      vectors++; if ({overflow, underflow} !== 2'b10) begin miscompares++; $display("FAIL ovf_hold[%0d] got %b exp 10", i, {overflow, underflow}); end
      drive(1'b0, 8'h00, 1'b0, r);
    end
    err_clear = 1'b1;
    drive(1'b0, 8'h00, 1'b0, r);
    err_clear = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    err_clear = 1'b1;
    drive(1'b1, 8'h98, 1'b0, r);
    err_clear = 1'b0;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_prio got %b exp 1", overflow); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fill_drop();
    test_full_pushpop();
    test_empty_pushpop();
    test_async_reset();
    test_random();
`ifdef FIFO_CHAIN_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
